// File: rtl/game_sequencer.sv
// Reaction-game sequencer: levels, score, lives and a synchronized game-speed tick.
// Optional round timeout (implied miss) enabled with `define SEQ_TIMEOUT_EN.
module game_sequencer #(
  parameter int HITS_PER_LEVEL = 8,
  parameter int START_LIVES    = 3,
  parameter int TIMEOUT_TICKS  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       hit,
  input  logic       miss,
  input  logic       speed_clk,
  input  logic       valid_start,
  output logic [7:0] level_sw,
  output logic [2:0] level,
  output logic [7:0] score,
  output logic [1:0] lives,
  output logic       round_tick,
  output logic       playing,
  output logic       game_over
);

  if (HITS_PER_LEVEL < 1 || HITS_PER_LEVEL > 255 || START_LIVES < 1 || START_LIVES > 3 ||
      TIMEOUT_TICKS < 1 || TIMEOUT_TICKS > 15) begin : g_bad_params
    $error("game_sequencer: parameter out of legal range");
  end

  localparam logic [7:0] HITS_L  = 8'(HITS_PER_LEVEL);
  localparam logic [1:0] LIVES_L = 2'(START_LIVES);
  localparam logic [2:0] MAX_LVL = 3'd6;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_PLAY      = 2'd1,
    S_LEVEL_UP  = 2'd2,
    S_GAME_OVER = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] level_q, level_d;
  logic [7:0] level_sw_q, level_sw_d;
  logic [7:0] score_q, score_d;
  logic [1:0] lives_q, lives_d;
  logic [7:0] hit_cnt_q, hit_cnt_d;
  logic       round_tick_q, round_tick_d;
  logic       playing_q, playing_d;
  logic       game_over_q, game_over_d;
  logic       spd_s1_q, spd_s2_q, spd_prev_q;
  logic       spd_edge_s;
  logic       tmo_fire_s;
  logic       miss_eff_s;

  function automatic logic [7:0] therm_code(input logic [2:0] lvl);
    case (lvl)
      3'd0:    therm_code = 8'h01;
      3'd1:    therm_code = 8'h03;
      3'd2:    therm_code = 8'h07;
      3'd3:    therm_code = 8'h0F;
      3'd4:    therm_code = 8'h1F;
      3'd5:    therm_code = 8'h3F;
      3'd6:    therm_code = 8'h7F;
      default: therm_code = 8'h01;
    endcase
  endfunction

`ifdef SEQ_TIMEOUT_EN
  localparam logic [3:0] TMO_L = 4'(TIMEOUT_TICKS);
  logic [3:0] tmo_cnt_q, tmo_cnt_d, tmo_inc_s;

  // Idle-round counter; any player action or leaving PLAY restarts it.
  always_comb begin
    tmo_inc_s  = tmo_cnt_q + {3'd0, round_tick_q};
    tmo_fire_s = (state_q == S_PLAY) && (tmo_inc_s == TMO_L);
    if (state_q != S_PLAY) begin
      tmo_cnt_d = 4'd0;
    end else if (hit || miss || tmo_fire_s) begin
      tmo_cnt_d = 4'd0;
    end else begin
      tmo_cnt_d = tmo_inc_s;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      tmo_cnt_q <= 4'd0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end
`else
  assign tmo_fire_s = 1'b0;
`endif

  assign spd_edge_s = spd_s2_q & ~spd_prev_q;
  assign miss_eff_s = miss | tmo_fire_s;

  // Next-state and datapath; a miss always wins over a coincident hit.
  always_comb begin
    state_d      = state_q;
    level_d      = level_q;
    score_d      = score_q;
    lives_d      = lives_q;
    hit_cnt_d    = hit_cnt_q;
    round_tick_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && valid_start) begin
          state_d = S_PLAY;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_PLAY: begin
        round_tick_d = spd_edge_s;
        if (miss_eff_s) begin
          if (lives_q <= 2'd1) begin
            lives_d = 2'd0;
            state_d = S_GAME_OVER;
          end else begin
            lives_d = lives_q - 2'd1;
          end
        end else if (hit) begin
          if (score_q != 8'hFF) begin
            score_d = score_q + 8'd1;
          end else begin
            score_d = score_q;
          end
          if ((hit_cnt_q + 8'd1) == HITS_L) begin
            hit_cnt_d = 8'd0;
            if (level_q < MAX_LVL) begin
              level_d = level_q + 3'd1;
              state_d = S_LEVEL_UP;
            end else begin
              level_d = level_q;
            end
          end else begin
            hit_cnt_d = hit_cnt_q + 8'd1;
          end
        end else begin
          state_d = S_PLAY;
        end
      end
      S_LEVEL_UP: begin
        state_d = S_PLAY;
      end
      S_GAME_OVER: begin
        if (start) begin
          state_d   = S_IDLE;
          level_d   = 3'd0;
          score_d   = 8'd0;
          lives_d   = LIVES_L;
          hit_cnt_d = 8'd0;
        end else begin
          state_d = S_GAME_OVER;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    level_sw_d  = therm_code(level_d);
    playing_d   = (state_d == S_PLAY) || (state_d == S_LEVEL_UP);
    game_over_d = (state_d == S_GAME_OVER);
  end

  // State, outputs and the speed_clk synchronizer.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      level_q      <= 3'd0;
      level_sw_q   <= 8'h01;
      score_q      <= 8'd0;
      lives_q      <= LIVES_L;
      hit_cnt_q    <= 8'd0;
      round_tick_q <= 1'b0;
      playing_q    <= 1'b0;
      game_over_q  <= 1'b0;
      spd_s1_q     <= 1'b0;
      spd_s2_q     <= 1'b0;
      spd_prev_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      level_q      <= level_d;
      level_sw_q   <= level_sw_d;
      score_q      <= score_d;
      lives_q      <= lives_d;
      hit_cnt_q    <= hit_cnt_d;
      round_tick_q <= round_tick_d;
      playing_q    <= playing_d;
      game_over_q  <= game_over_d;
      spd_s1_q     <= speed_clk;
      spd_s2_q     <= spd_s1_q;
      spd_prev_q   <= spd_s2_q;
    end
  end

  assign level_sw   = level_sw_q;
  assign level      = level_q;
  assign score      = score_q;
  assign lives      = lives_q;
  assign round_tick = round_tick_q;
  assign playing    = playing_q;
  assign game_over  = game_over_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed self-checking bench for game_sequencer (default parameters).
module tb_game_sequencer;

  logic       clk = 1'b0;
  logic       rst, start, hit, miss, speed_clk, valid_start;
  logic [7:0] level_sw;
  logic [2:0] level;
  logic [7:0] score;
  logic [1:0] lives;
  logic       round_tick, playing, game_over;

  int n_tests = 0;
  int n_fail  = 0;

  game_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .hit        (hit),
    .miss       (miss),
    .speed_clk  (speed_clk),
    .valid_start(valid_start),
    .level_sw   (level_sw),
    .level      (level),
    .score      (score),
    .lives      (lives),
    .round_tick (round_tick),
    .playing    (playing),
    .game_over  (game_over)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_hits(input int n);
    for (int i = 0; i < n; i++) begin
      hit = 1'b1;
      tick();
      hit = 1'b0;
      tick();
    end
  endtask

  task automatic do_miss();
    miss = 1'b1;
    tick();
    miss = 1'b0;
    tick();
  endtask

  task automatic check_reset_state(input string tag);
    check_val({tag, "_level"}, 32'(level), 32'd0);
    check_val({tag, "_level_sw"}, 32'(level_sw), 32'h01);
    check_val({tag, "_score"}, 32'(score), 32'd0);
    check_val({tag, "_lives"}, 32'(lives), 32'd3);
    check_val({tag, "_playing"}, 32'(playing), 32'd0);
    check_val({tag, "_game_over"}, 32'(game_over), 32'd0);
    check_val({tag, "_round_tick"}, 32'(round_tick), 32'd0);
  endtask

  initial begin
    int exp_lives;
    rst = 1'b0; start = 1'b0; hit = 1'b0; miss = 1'b0;
    speed_clk = 1'b0; valid_start = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    check_reset_state("reset");

    pulse_start();
    check_val("start_invalid_ignored", 32'(playing), 32'd0);

    valid_start = 1'b1;
    pulse_start();
    check_val("start_playing", 32'(playing), 32'd1);
    check_val("start_level", 32'(level), 32'd0);
    check_val("start_level_sw", 32'(level_sw), 32'h01);
    check_val("start_lives", 32'(lives), 32'd3);

    do_hits(7);
    check_val("seven_hits_level", 32'(level), 32'd0);
    check_val("seven_hits_score", 32'(score), 32'd7);
    hit = 1'b1;
    tick();
    check_val("lvlup_playing", 32'(playing), 32'd1);
    check_val("lvlup_level", 32'(level), 32'd1);
    check_val("lvlup_level_sw", 32'(level_sw), 32'h03);
    check_val("lvlup_score", 32'(score), 32'd8);
    tick();
    hit = 1'b0;
    check_val("lvlup_hit_discarded", 32'(score), 32'd8);

    pulse_start();
    check_val("start_in_play_ignored", 32'(playing), 32'd1);

    do_miss();
    check_val("miss_lives", 32'(lives), 32'd2);
    hit = 1'b1;
    miss = 1'b1;
    tick();
    hit = 1'b0;
    miss = 1'b0;
    check_val("hit_miss_lives", 32'(lives), 32'd1);
    check_val("hit_miss_score", 32'(score), 32'd8);

    do_hits(40);
    check_val("max_level", 32'(level), 32'd6);
    check_val("max_level_sw", 32'(level_sw), 32'h7F);
    check_val("max_level_score", 32'(score), 32'd48);
    do_hits(8);
    check_val("wrap_level", 32'(level), 32'd6);
    check_val("wrap_level_sw", 32'(level_sw), 32'h7F);
    check_val("wrap_playing", 32'(playing), 32'd1);
    check_val("wrap_score", 32'(score), 32'd56);
    do_hits(244);
    check_val("score_saturate", 32'(score), 32'd255);

    do_miss();
    check_val("over_lives", 32'(lives), 32'd0);
    check_val("over_flag", 32'(game_over), 32'd1);
    check_val("over_playing", 32'(playing), 32'd0);
    check_val("over_level_held", 32'(level), 32'd6);
    do_hits(1);
    check_val("over_hit_ignored", 32'(score), 32'd255);
    pulse_start();
    check_reset_state("restart");

    pulse_start();
    do_hits(3);
    do_miss();
    do_miss();
    check_val("g2_two_misses", 32'(lives), 32'd1);
    do_miss();
    check_val("g2_lives0", 32'(lives), 32'd0);
    check_val("g2_over", 32'(game_over), 32'd1);
    check_val("g2_score_held", 32'(score), 32'd3);
    pulse_start();
    check_val("g2_idle_score", 32'(score), 32'd0);
    check_val("g2_idle_lives", 32'(lives), 32'd3);

    pulse_start();
    for (int e = 0; e < 4; e++) begin
      speed_clk = 1'b1;
      tick();
      tick();
      if (e == 0) begin
        check_val("tick_early", 32'(round_tick), 32'd0);
      end
      tick();
      if (e == 0) begin
        check_val("tick_latency", 32'(round_tick), 32'd1);
      end
      tick();
      if (e == 0) begin
        check_val("tick_one_cycle", 32'(round_tick), 32'd0);
      end
      speed_clk = 1'b0;
      repeat (4) tick();
    end
`ifdef SEQ_TIMEOUT_EN
    exp_lives = 2;
`else
    exp_lives = 3;
`endif
    check_val("timeout_lives", 32'(lives), 32'(exp_lives));

    do_hits(2);
    check_val("pre_reset_score", 32'(score), 32'd2);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check_reset_state("midgame_reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
